// File: rtl/fft_result_streamer.sv
// Holds one captured FFT result frame and streams it bin by bin over a valid/ready port.
// Inverse-transform frames are scaled by 1/D_WIDTH on the way out.
module fft_result_streamer #(
    parameter int D_WIDTH     = 64,
    parameter int LOG_2_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     capture,
    input  logic                     ifft,
    input  logic [16*D_WIDTH-1:0]    in_Re,
    input  logic [16*D_WIDTH-1:0]    in_Im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_Re,
    output logic [15:0]              out_Im,
    output logic [LOG_2_WIDTH-1:0]   out_index,
    output logic                     out_last,
    output logic                     busy,
    output logic                     overrun
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [LOG_2_WIDTH-1:0] LAST_INDEX = LOG_2_WIDTH'(D_WIDTH - 1);

    state_t                   state_reg, state_next;
    logic [LOG_2_WIDTH-1:0]   index_reg, index_next;
    logic                     mode_reg, mode_next;
    logic                     overrun_reg, overrun_next;
    logic [15:0]              buf_re [D_WIDTH];
    logic [15:0]              buf_im [D_WIDTH];
    logic [15:0]              in_re_word [D_WIDTH];
    logic [15:0]              in_im_word [D_WIDTH];
    logic                     streaming, transfer, at_last, accept;
    logic [15:0]              sel_re, sel_im;

    genvar gi;
    generate
        for (gi = 0; gi < D_WIDTH; gi++) begin : g_unpack
            assign in_re_word[gi] = in_Re[16*gi +: 16];
            assign in_im_word[gi] = in_Im[16*gi +: 16];
        end
    endgenerate

    // A capture is only taken when idle or on the very edge that retires the last bin.
    always_comb begin
        streaming    = (state_reg == STREAM);
        transfer     = streaming && out_ready;
        at_last      = (index_reg == LAST_INDEX);
        accept       = capture && (!streaming || (transfer && at_last));
        state_next   = state_reg;
        index_next   = index_reg;
        mode_next    = mode_reg;
        overrun_next = overrun_reg;
        if (accept) begin
            state_next   = STREAM;
            index_next   = '0;
            mode_next    = ifft;
            overrun_next = 1'b0;
        end else if (streaming) begin
            if (capture) begin
                overrun_next = 1'b1;
            end
            if (transfer) begin
                if (at_last) begin
                    state_next = IDLE;
                    index_next = '0;
                end else begin
                    index_next = index_reg + 1'b1;
                end
            end
        end
    end

    // The FFT core updates on the falling edge, so this block follows suit.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            index_reg   <= '0;
            mode_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            index_reg   <= index_next;
            mode_reg    <= mode_next;
            overrun_reg <= overrun_next;
        end
    end

    // Whole frame lands in one edge, so the buffer is a register file rather than a RAM.
    always_ff @(negedge clk) begin
        if (accept) begin
            for (int i = 0; i < D_WIDTH; i++) begin
                buf_re[i] <= in_re_word[i];
                buf_im[i] <= in_im_word[i];
            end
        end
    end

    // Kept as if/else so the arithmetic shift stays in a signed context.
    always_comb begin
        sel_re = buf_re[index_reg];
        sel_im = buf_im[index_reg];
        if (!streaming) begin
            out_Re = '0;
            out_Im = '0;
        end else if (mode_reg) begin
            out_Re = $signed(sel_re) >>> LOG_2_WIDTH;
            out_Im = $signed(sel_im) >>> LOG_2_WIDTH;
        end else begin
            out_Re = sel_re;
            out_Im = sel_im;
        end
    end

    assign out_valid = streaming;
    assign busy      = streaming;
    assign out_index = streaming ? index_reg : '0;
    assign out_last  = streaming && at_last;
    assign overrun   = overrun_reg;

endmodule
